ppfifo_data_source: RTL and testbench
=====================================

# ppfifo_data_source

Pattern-generating producer for the write side of a ping-pong FIFO. It acquires whichever buffer the FIFO reports ready and fills it with a deterministic data pattern, then releases it and repeats while enabled. It sits directly upstream of the ping-pong FIFO and provides known traffic for bring-up and for loopback tests of the DMA datapath.

## Interface
Parameters:
- DATA_WIDTH, 32, width of written data words
- SIZE_WIDTH, 24, width of buffer size and count fields

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- i_enable  in  1  high: keep acquiring and filling buffers
- i_mode  in  1  0: incrementing pattern; 1: LFSR pattern (only with PPFIFO_SOURCE_LFSR_EN)
- i_max_count  in  SIZE_WIDTH  words per buffer cap; 0 means use i_wr_size
- i_wr_rdy  in  2  per-buffer ready from the FIFO
- o_wr_act  out  2  one-hot buffer-active grant
- i_wr_size  in  SIZE_WIDTH  buffer capacity in words
- o_wr_stb  out  1  write strobe, one word per high cycle
- o_wr_data  out  DATA_WIDTH  write data, valid while o_wr_stb is high
- o_busy  out  1  high whenever the state machine is not IDLE
- o_buffer_count  out  32  number of buffers released since reset; wraps modulo 2^32

## Operation
- States:
  - IDLE: o_wr_act = 0.
    - When i_enable && i_wr_rdy != 0, grant bit 0 if i_wr_rdy[0] is set, else bit 1.
    - Latch limit = (i_max_count == 0 || i_max_count > i_wr_size) ? i_wr_size : i_max_count.
    - Latch i_mode, clear r_count, go to WRITE.
  - WRITE: if r_count < limit, register o_wr_stb = 1 and o_wr_data = current pattern value, advance the pattern, r_count++. Otherwise clear o_wr_act, increment o_buffer_count, go to DONE.
  - DONE: one guard cycle so the FIFO can drop rdy for the released buffer, then go to IDLE.
- A buffer, once granted, is always filled to the limit. Dropping i_enable mid-buffer only prevents the next acquisition.
- limit == 0: the buffer is granted and released with no strobes. o_buffer_count still increments.
- Incrementing pattern: a counter starting at 0 after reset. It advances per strobe, continues across buffers, and wraps from all-ones to 0.
- o_wr_stb is never high while o_wr_act == 0. o_wr_act is never 2'b11.
- i_wr_size and i_max_count are sampled only at grant. Changes mid-buffer have no effect on the current buffer.
- o_busy = (state != IDLE), decoded combinationally from the state register.

## Timing
- Reset values: o_wr_act = 0, o_wr_stb = 0, o_wr_data = 0, o_buffer_count = 0, o_busy = 0. Pattern counter = 0, LFSR = 0x00000001, state = IDLE.
- Reset mid-buffer: all of the above take effect on the next edge, and no release handshake is issued.
- Cycle numbering: cycle 0 is the first cycle o_wr_act is high; it rises one cycle after IDLE samples rdy && enable.
- Strobes occupy cycles 1..N (N = limit), back to back with no gaps.
- o_wr_act falls in cycle N+1. The state is IDLE in cycle N+2, so the earliest next grant is cycle N+3.
- o_buffer_count updates in the same cycle o_wr_act falls.

## Configuration
- PPFIFO_SOURCE_LFSR_EN defined: an LFSR pattern generator is compiled in.
  - With i_mode latched as 1, each strobe outputs the current LFSR value, then advances it: next = {cur[30:0], cur[31]^cur[21]^cur[1]^cur[0]}.
  - The LFSR is seeded to 0x00000001 at reset only and continues across buffers.
  - For DATA_WIDTH > 32, the upper bits are zero.
- PPFIFO_SOURCE_LFSR_EN undefined: there is no LFSR logic, i_mode is ignored, and the pattern is always incrementing.

## Test plan
- Two buffers: rst, then i_enable=1, i_wr_rdy=2'b11, i_wr_size=4, i_max_count=0, i_mode=0 -> o_wr_act=01 with data 0,1,2,3 on cycles 1..4, released in cycle 5; next grant 10 with data 4,5,6,7; o_buffer_count=2.
- Size cap: i_wr_size=8, i_max_count=3 -> exactly 3 strobes per buffer; i_max_count=20 -> 8 strobes.
- Enable dropped after the 2nd of 8 strobes -> all 8 strobes complete, the buffer is released, and no further o_wr_act while i_wr_rdy=2'b11.
- Buffer select: i_wr_rdy=2'b10 -> o_wr_act=10.
- Zero size: i_wr_size=0 -> o_wr_act high for one cycle, no strobes, o_buffer_count increments.
- LFSR (PPFIFO_SOURCE_LFSR_EN defined): i_mode=1, size 4 -> data 0x00000001, 0x00000003, 0x00000006, 0x0000000D.
- Reset mid-buffer: rst for 1 cycle after the 2nd strobe -> o_wr_act=00, o_wr_stb=0, o_buffer_count=0; next buffer data restarts at 0.

Source files
------------

// File: rtl/ppfifo_data_source_if.sv
// Write-side handshake between the pattern source (master) and the ping-pong FIFO (slave).
interface ppfifo_data_source_if #(
  parameter int DATA_WIDTH = 32,
  parameter int SIZE_WIDTH = 24
);
  logic [1:0]            i_wr_rdy;
  logic [1:0]            o_wr_act;
  logic [SIZE_WIDTH-1:0] i_wr_size;
  logic                  o_wr_stb;
  logic [DATA_WIDTH-1:0] o_wr_data;

  modport master (
    input  i_wr_rdy,
    input  i_wr_size,
    output o_wr_act,
    output o_wr_stb,
    output o_wr_data
  );

  modport slave (
    output i_wr_rdy,
    output i_wr_size,
    input  o_wr_act,
    input  o_wr_stb,
    input  o_wr_data
  );
endinterface

// File: rtl/ppfifo_data_source.sv
// Pattern producer that acquires a ready ping-pong FIFO buffer, fills it, and releases it.
// Define PPFIFO_SOURCE_LFSR_EN to compile in the LFSR pattern selected by i_mode.
module ppfifo_data_source #(
  parameter int DATA_WIDTH = 32,
  parameter int SIZE_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_enable,
  input  logic                  i_mode,
  input  logic [SIZE_WIDTH-1:0] i_max_count,
  ppfifo_data_source_if.master  wr_if,
  output logic                  o_busy,
  output logic [31:0]           o_buffer_count
);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    DONE
  } state_t;

  state_t                state_q;
  logic [1:0]            wr_act_q;
  logic                  wr_stb_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic [SIZE_WIDTH-1:0] limit_q;
  logic [SIZE_WIDTH-1:0] limit_d;
  logic [SIZE_WIDTH-1:0] count_q;
  logic [31:0]           buffer_count_q;
  logic [DATA_WIDTH-1:0] inc_q;
  logic [DATA_WIDTH-1:0] pattern_d;

`ifdef PPFIFO_SOURCE_LFSR_EN
  logic        mode_q;
  logic [31:0] lfsr_q;
  logic [31:0] lfsr_d;

  always_comb begin
    lfsr_d    = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
    pattern_d = mode_q ? DATA_WIDTH'(lfsr_q) : inc_q;
  end
`else
  logic unusedMode;

  assign unusedMode = i_mode;
  assign pattern_d  = inc_q;
`endif

  // A zero or oversized cap falls back to the full buffer capacity.
  assign limit_d = (i_max_count == '0 || i_max_count > wr_if.i_wr_size) ?
                   wr_if.i_wr_size : i_max_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      wr_act_q       <= 2'b00;
      wr_stb_q       <= 1'b0;
      wr_data_q      <= '0;
      limit_q        <= '0;
      count_q        <= '0;
      buffer_count_q <= 32'd0;
      inc_q          <= '0;
`ifdef PPFIFO_SOURCE_LFSR_EN
      mode_q         <= 1'b0;
      lfsr_q         <= 32'h0000_0001;
`endif
    end else begin
      wr_stb_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_enable && wr_if.i_wr_rdy != 2'b00) begin
            wr_act_q <= wr_if.i_wr_rdy[0] ? 2'b01 : 2'b10;
            limit_q  <= limit_d;
            count_q  <= '0;
`ifdef PPFIFO_SOURCE_LFSR_EN
            mode_q   <= i_mode;
`endif
            state_q  <= WRITE;
          end
        end
        WRITE: begin
          if (count_q < limit_q) begin
            wr_stb_q  <= 1'b1;
            wr_data_q <= pattern_d;
            count_q   <= count_q + SIZE_WIDTH'(1);
`ifdef PPFIFO_SOURCE_LFSR_EN
            if (mode_q) begin
              lfsr_q <= lfsr_d;
            end else begin
              inc_q <= inc_q + DATA_WIDTH'(1);
            end
`else
            inc_q <= inc_q + DATA_WIDTH'(1);
`endif
          end else begin
            wr_act_q       <= 2'b00;
            buffer_count_q <= buffer_count_q + 32'd1;
            state_q        <= DONE;
          end
        end
        // Guard cycle lets the FIFO drop rdy for the buffer just released.
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign wr_if.o_wr_act  = wr_act_q;
  assign wr_if.o_wr_stb  = wr_stb_q;
  assign wr_if.o_wr_data = wr_data_q;
  assign o_busy          = (state_q != IDLE);
  assign o_buffer_count  = buffer_count_q;

endmodule

// File: tb/tb_ppfifo_data_source.sv
// Randomized bench for ppfifo_data_source against a cycle-numbered buffer reference model.
module tb_ppfifo_data_source;
  localparam int DW = 32;
  localparam int SW = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          mode;
  logic [SW-1:0] maxCount;
  logic          busy;
  logic [31:0]   bufferCount;

  int checks   = 0;
  int failures = 0;

  // Reference model: position within the current buffer, counted from the grant cycle.
  int          cyc = -1;
  int          mLimit = 0;
  logic [1:0]  mGrant = 2'b00;
  logic        mMode = 1'b0;
  logic [31:0] mInc = 32'd0;
  logic [31:0] mLfsr = 32'd1;
  logic [31:0] mBufCount = 32'd0;
  logic [1:0]  eAct;
  logic        eStb;
  logic [31:0] eData;

  ppfifo_data_source_if #(.DATA_WIDTH(DW), .SIZE_WIDTH(SW)) wrIf ();

  ppfifo_data_source #(.DATA_WIDTH(DW), .SIZE_WIDTH(SW)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_enable       (enable),
    .i_mode         (mode),
    .i_max_count    (maxCount),
    .wr_if          (wrIf),
    .o_busy         (busy),
    .o_buffer_count (bufferCount)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic stepModel();
    int  size;
    int  maxc;
    logic useLfsr;
    size = int'(wrIf.i_wr_size);
    maxc = int'(maxCount);
    if (rst) begin
      cyc       = -1;
      mInc      = 32'd0;
      mLfsr     = 32'd1;
      mBufCount = 32'd0;
    end else if (cyc < 0) begin
      if (enable && wrIf.i_wr_rdy != 2'b00) begin
        cyc    = 0;
        mGrant = wrIf.i_wr_rdy[0] ? 2'b01 : 2'b10;
        mLimit = (maxc == 0 || maxc > size) ? size : maxc;
        mMode  = mode;
      end
    end else begin
      cyc++;
      if (cyc == mLimit + 1) mBufCount++;
      if (cyc == mLimit + 2) cyc = -1;
    end
    eAct = (cyc >= 0 && cyc <= mLimit) ? mGrant : 2'b00;
    eStb = (cyc >= 1 && cyc <= mLimit);
    useLfsr = 1'b0;
`ifdef PPFIFO_SOURCE_LFSR_EN
    useLfsr = mMode;
`endif
    if (eStb) begin
      if (useLfsr) begin
        eData = mLfsr;
        mLfsr = {mLfsr[30:0], mLfsr[31] ^ mLfsr[21] ^ mLfsr[1] ^ mLfsr[0]};
      end else begin
        eData = mInc;
        mInc  = mInc + 32'd1;
      end
    end
  endtask

  task automatic applyStimulus(input logic r, input logic en, input logic md,
                               input logic [1:0] rdy, input int size, input int maxc);
    rst            = r;
    enable         = en;
    mode           = md;
    wrIf.i_wr_rdy  = rdy;
    wrIf.i_wr_size = SW'(size);
    maxCount       = SW'(maxc);
    @(posedge clk);
    #1;
    stepModel();
    checkOutput("wrAct", 64'(wrIf.o_wr_act), 64'(eAct));
    checkOutput("wrStb", 64'(wrIf.o_wr_stb), 64'(eStb));
    checkOutput("busy", 64'(busy), 64'(cyc != -1));
    checkOutput("bufferCount", 64'(bufferCount), 64'(mBufCount));
    if (eStb) checkOutput("wrData", 64'(wrIf.o_wr_data), 64'(eData));
    if (r) checkOutput("resetData", 64'(wrIf.o_wr_data), 64'd0);
  endtask

  initial begin
    // Two back-to-back buffers of four incrementing words.
    repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 4, 0);
    repeat (14) applyStimulus(1'b0, 1'b1, 1'b0, 2'b11, 4, 0);

    // Size capping, buffer select and zero-size buffers.
    repeat (12) applyStimulus(1'b0, 1'b1, 1'b0, 2'b11, 8, 3);
    repeat (12) applyStimulus(1'b0, 1'b1, 1'b0, 2'b10, 8, 20);
    repeat (8)  applyStimulus(1'b0, 1'b1, 1'b0, 2'b11, 0, 0);

    // Enable dropped mid-buffer: current buffer completes, no new grant.
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 8, 0);
    repeat (3)  applyStimulus(1'b0, 1'b1, 1'b0, 2'b11, 8, 0);
    repeat (16) applyStimulus(1'b0, 1'b0, 1'b0, 2'b11, 8, 0);

    // LFSR buffer (falls back to incrementing when the option is absent).
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 4, 0);
    repeat (8) applyStimulus(1'b0, 1'b1, 1'b1, 2'b11, 4, 0);

    // Reset after the second strobe, then refill from zero.
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 8, 0);
    repeat (3)  applyStimulus(1'b0, 1'b1, 1'b0, 2'b11, 8, 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 2'b11, 8, 0);
    repeat (12) applyStimulus(1'b0, 1'b1, 1'b0, 2'b11, 8, 0);

    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 399) == 0,
                    $urandom_range(0, 7) != 0,
                    1'($urandom_range(0, 1)),
                    2'($urandom_range(0, 3)),
                    int'($urandom_range(0, 9)),
                    int'($urandom_range(0, 12)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end
endmodule
